// File: rtl/box_stat_acc.sv
// Per-level statistics over the grouped-box write stream: non-empty count, sum, sum of squares
// and (with BOX_STAT_MAX_EN defined) maximum mass, handed downstream over valid/ready.
module box_stat_acc #(
  parameter int BOX_IDX = 3,
  parameter int DW      = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      level_start,
  input  logic [BOX_IDX-1:0]        side_log,
  input  logic                      wen_in,
  input  logic [DW-1:0]             y_in,
  input  logic                      stat_ready,
  output logic                      busy,
  output logic                      stat_valid,
  output logic [2*BOX_IDX-2:0]      nz_cnt,
  output logic [DW+2*BOX_IDX-1:0]   sum,
  output logic [2*DW+2*BOX_IDX-1:0] sumsq,
  output logic [DW-1:0]             max_val,
  output logic                      err
);
  localparam int CW = 2*BOX_IDX-1;
  localparam int SW = DW+2*BOX_IDX;
  localparam int QW = 2*DW+2*BOX_IDX;
  localparam logic [BOX_IDX-1:0] SIDE_MAX = BOX_IDX'(BOX_IDX-1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n, tgt, tgt_n, nz_n;
  logic [SW-1:0]     sum_n;
  logic [QW-1:0]     sq_n;
  logic [2*DW-1:0]   sq;
  logic              err_n;
  logic              side_bad, start_ok, acc_wr;
  logic [BOX_IDX-1:0] side_c;

  assign side_bad = side_log > SIDE_MAX;
  assign side_c   = side_bad ? SIDE_MAX : side_log;
  // A start in HOLD is only honoured when it coincides with the handshake.
  assign start_ok = level_start && (state != HOLD || stat_ready);
  assign acc_wr   = wen_in && (state == ACC);
  assign sq       = {{DW{1'b0}}, y_in} * {{DW{1'b0}}, y_in};

  assign busy       = (state == ACC);
  assign stat_valid = (state == HOLD);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tgt_n   = tgt;
    nz_n    = nz_cnt;
    sum_n   = sum;
    sq_n    = sumsq;
    err_n   = err;
    if (state == HOLD && stat_ready) state_n = IDLE;
    if (start_ok) begin
      cnt_n   = '0;
      nz_n    = '0;
      sum_n   = '0;
      sq_n    = '0;
      tgt_n   = CW'(1) << {side_c, 1'b0};
      err_n   = err | side_bad;
      state_n = ACC;
    end
    if (wen_in && state != ACC) err_n = 1'b1;
    // A write coincident with a restart lands on the freshly cleared level.
    if (acc_wr) begin
      cnt_n = cnt_n + CW'(1);
      nz_n  = nz_n + CW'(y_in != '0);
      sum_n = sum_n + SW'(y_in);
      sq_n  = sq_n + QW'(sq);
      if (cnt_n == tgt_n) state_n = HOLD;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      tgt    <= '0;
      nz_cnt <= '0;
      sum    <= '0;
      sumsq  <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      tgt    <= tgt_n;
      nz_cnt <= nz_n;
      sum    <= sum_n;
      sumsq  <= sq_n;
      err    <= err_n;
    end
  end

`ifdef BOX_STAT_MAX_EN
  logic [DW-1:0] max_n;

  always_comb begin
    max_n = max_val;
    if (start_ok) max_n = '0;
    if (acc_wr && y_in > max_n) max_n = y_in;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) max_val <= '0;
    else     max_val <= max_n;
  end
`else
  assign max_val = '0;
`endif

endmodule

// File: tb/tb_box_stat_acc.sv
// Randomized self-checking bench for box_stat_acc against a queue-based statistics model.
module tb_box_stat_acc;
  localparam int BOX_IDX = 3;
  localparam int DW      = 8;

  logic                      CLK = 1'b0;
  logic                      RST = 1'b1;
  logic                      level_start = 1'b0;
  logic [BOX_IDX-1:0]        side_log = '0;
  logic                      wen_in = 1'b0;
  logic [DW-1:0]             y_in = '0;
  logic                      stat_ready = 1'b0;
  logic                      busy, stat_valid, err;
  logic [2*BOX_IDX-2:0]      nz_cnt;
  logic [DW+2*BOX_IDX-1:0]   sum;
  logic [2*DW+2*BOX_IDX-1:0] sumsq;
  logic [DW-1:0]             max_val;

  int total = 0;
  int passed = 0;
  int en, es, eq, em;
  int ys[$];

  box_stat_acc #(.BOX_IDX(BOX_IDX), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .level_start(level_start), .side_log(side_log),
    .wen_in(wen_in), .y_in(y_in), .stat_ready(stat_ready), .busy(busy),
    .stat_valid(stat_valid), .nz_cnt(nz_cnt), .sum(sum), .sumsq(sumsq),
    .max_val(max_val), .err(err)
  );

  always #5 CLK = ~CLK;

  // Reference: statistics of the accepted write list, straight from the definitions.
  task automatic model(input int q[$]);
    en = 0; es = 0; eq = 0; em = 0;
    foreach (q[i]) begin
      if (q[i] != 0) en++;
      es += q[i];
      eq += q[i] * q[i];
      if (q[i] > em) em = q[i];
    end
`ifndef BOX_STAT_MAX_EN
    em = 0;
`endif
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input int side);
    level_start = 1'b1;
    side_log = side[BOX_IDX-1:0];
    tick();
    level_start = 1'b0;
  endtask

  task automatic wr(input int y);
    wen_in = 1'b1;
    y_in = y[DW-1:0];
    tick();
    wen_in = 1'b0;
  endtask

  task automatic release_stats();
    stat_ready = 1'b1;
    tick();
    stat_ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || stat_valid !== 1'b0 || nz_cnt !== 0 || sum !== 0 ||
        sumsq !== 0 || max_val !== 0 || err !== 1'b0)
      $display("FAIL reset_state: busy=%b valid=%b nz=%0d sum=%0d sq=%0d max=%0d err=%b, want all 0",
               busy, stat_valid, nz_cnt, sum, sumsq, max_val, err);
    else passed++;
    wr(9);
    total++;
    if (err !== 1'b1 || nz_cnt !== 0 || sum !== 0)
      $display("FAIL idle_overrun: err=%b nz=%0d sum=%0d, want err=1 nz=0 sum=0", err, nz_cnt, sum);
    else passed++;
    start(1); wr(4); wr(6);
    total++;
    if (busy !== 1'b1 || sum !== 10)
      $display("FAIL pre_reset_acc: busy=%b sum=%0d, want busy=1 sum=10", busy, sum);
    else passed++;
    #2 RST = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || stat_valid !== 1'b0 || nz_cnt !== 0 || sum !== 0 ||
        sumsq !== 0 || max_val !== 0 || err !== 1'b0)
      $display("FAIL mid_reset: busy=%b valid=%b nz=%0d sum=%0d sq=%0d max=%0d err=%b, want all 0",
               busy, stat_valid, nz_cnt, sum, sumsq, max_val, err);
    else passed++;
    tick();
    RST = 1'b0;
    start(0); wr(7);
    ys = {7}; model(ys);
    total++;
    if (stat_valid !== 1'b1 || nz_cnt !== en || sum !== es || sumsq !== eq || max_val !== em || err !== 1'b0)
      $display("FAIL post_reset_level: valid=%b nz=%0d sum=%0d sq=%0d max=%0d err=%b, want 1 %0d %0d %0d %0d 0",
               stat_valid, nz_cnt, sum, sumsq, max_val, err, en, es, eq, em);
    else passed++;
    release_stats();
  endtask

  task automatic test_single();
    start(0); wr(5);
    ys = {5}; model(ys);
    total++;
    if (stat_valid !== 1'b1 || busy !== 1'b0 || nz_cnt !== en || sum !== es || sumsq !== eq || max_val !== em)
      $display("FAIL single_stats: valid=%b busy=%b nz=%0d sum=%0d sq=%0d max=%0d, want 1 0 %0d %0d %0d %0d",
               stat_valid, busy, nz_cnt, sum, sumsq, max_val, en, es, eq, em);
    else passed++;
    release_stats();
    total++;
    if (stat_valid !== 1'b0 || busy !== 1'b0 || sum !== es || sumsq !== eq)
      $display("FAIL single_release: valid=%b busy=%b sum=%0d sq=%0d, want 0 0 %0d %0d",
               stat_valid, busy, sum, sumsq, es, eq);
    else passed++;
  endtask

  task automatic test_gaps();
    start(1);
    wr(3); tick(); tick();
    wr(0); tick();
    wr(2); tick(); tick(); tick();
    total++;
    if (stat_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL gaps_before_last: valid=%b busy=%b, want 0 1", stat_valid, busy);
    else passed++;
    wr(255);
    ys = {3, 0, 2, 255}; model(ys);
    for (int i = 0; i < 10; i++) begin
      total++;
      if (stat_valid !== 1'b1 || nz_cnt !== en || sum !== es || sumsq !== eq || max_val !== em)
        $display("FAIL gaps_hold[%0d]: valid=%b nz=%0d sum=%0d sq=%0d max=%0d, want 1 %0d %0d %0d %0d",
                 i, stat_valid, nz_cnt, sum, sumsq, max_val, en, es, eq, em);
      else passed++;
      tick();
    end
    release_stats();
  endtask

  task automatic test_full();
    ys = {};
    start(2);
    for (int i = 0; i < 15; i++) begin wr(255); ys.push_back(255); end
    total++;
    if (stat_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL full_15: valid=%b busy=%b, want 0 1", stat_valid, busy);
    else passed++;
    wr(255); ys.push_back(255); model(ys);
    total++;
    if (stat_valid !== 1'b1 || nz_cnt !== en || sum !== es || sumsq !== eq || max_val !== em)
      $display("FAIL full_16: valid=%b nz=%0d sum=%0d sq=%0d max=%0d, want 1 %0d %0d %0d %0d",
               stat_valid, nz_cnt, sum, sumsq, max_val, en, es, eq, em);
    else passed++;
    release_stats();
  endtask

  task automatic test_overrun_restart();
    start(0); wr(9);
    wr(100);
    ys = {9}; model(ys);
    total++;
    if (err !== 1'b1 || stat_valid !== 1'b1 || nz_cnt !== en || sum !== es || sumsq !== eq || max_val !== em)
      $display("FAIL hold_overrun: err=%b valid=%b nz=%0d sum=%0d sq=%0d max=%0d, want 1 1 %0d %0d %0d %0d",
               err, stat_valid, nz_cnt, sum, sumsq, max_val, en, es, eq, em);
    else passed++;
    stat_ready = 1'b1;
    start(1);
    stat_ready = 1'b0;
    total++;
    if (busy !== 1'b1 || stat_valid !== 1'b0 || nz_cnt !== 0 || sum !== 0 || sumsq !== 0 || max_val !== 0)
      $display("FAIL handshake_start: busy=%b valid=%b nz=%0d sum=%0d sq=%0d max=%0d, want 1 0 0 0 0 0",
               busy, stat_valid, nz_cnt, sum, sumsq, max_val);
    else passed++;
    wr(11); wr(12);
    // restart mid-level with a coincident write: it belongs to the new one-box level
    level_start = 1'b1; side_log = 3'd0;
    wr(7);
    level_start = 1'b0;
    ys = {7}; model(ys);
    total++;
    if (stat_valid !== 1'b1 || nz_cnt !== en || sum !== es || sumsq !== eq || max_val !== em)
      $display("FAIL acc_restart: valid=%b nz=%0d sum=%0d sq=%0d max=%0d, want 1 %0d %0d %0d %0d",
               stat_valid, nz_cnt, sum, sumsq, max_val, en, es, eq, em);
    else passed++;
    level_start = 1'b1; side_log = 3'd1;
    tick();
    level_start = 1'b0;
    total++;
    if (stat_valid !== 1'b1 || busy !== 1'b0 || sum !== es)
      $display("FAIL hold_start_ignored: valid=%b busy=%b sum=%0d, want 1 0 %0d", stat_valid, busy, sum, es);
    else passed++;
    release_stats();
  endtask

  task automatic test_bad_side();
    RST = 1'b1; tick(); RST = 1'b0;
    start(3);
    total++;
    if (err !== 1'b1 || busy !== 1'b1)
      $display("FAIL bad_side_err: err=%b busy=%b, want 1 1", err, busy);
    else passed++;
    ys = {};
    for (int i = 0; i < 16; i++) begin
      int y = $urandom_range(0, 255);
      wr(y); ys.push_back(y);
      if (i == 14) begin
        total++;
        if (stat_valid !== 1'b0)
          $display("FAIL bad_side_early: valid=%b after 15 writes, want 0", stat_valid);
        else passed++;
      end
    end
    model(ys);
    total++;
    if (stat_valid !== 1'b1 || nz_cnt !== en || sum !== es || sumsq !== eq || max_val !== em)
      $display("FAIL bad_side_stats: valid=%b nz=%0d sum=%0d sq=%0d max=%0d, want 1 %0d %0d %0d %0d",
               stat_valid, nz_cnt, sum, sumsq, max_val, en, es, eq, em);
    else passed++;
    release_stats();
  endtask

  task automatic test_random();
    for (int lv = 0; lv < 25; lv++) begin
      int side = $urandom_range(0, 2);
      int n = 1 << (2 * side);
      ys = {};
      start(side);
      for (int i = 0; i < n; i++) begin
        int y = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        wr(y); ys.push_back(y);
      end
      model(ys);
      for (int h = $urandom_range(0, 3); h >= 0; h--) begin
        total++;
        if (stat_valid !== 1'b1 || nz_cnt !== en || sum !== es || sumsq !== eq || max_val !== em)
          $display("FAIL random_lv%0d: valid=%b nz=%0d sum=%0d sq=%0d max=%0d, want 1 %0d %0d %0d %0d",
                   lv, stat_valid, nz_cnt, sum, sumsq, max_val, en, es, eq, em);
        else passed++;
        if (h > 0) tick();
      end
      release_stats();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_full();
    test_overrun_restart();
    test_bad_side();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
